// File: rtl/mem_pkg.sv
// Shared encodings for the RV32I MEM stage: write-back selects, funct3 access
// sizes and the bus FSM state type.
package mem_pkg;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DRAM = 2'd1;
  localparam logic [1:0] WD_EXT  = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane steering for the MEM stage: store enables/data replication, load
// byte/half extraction with sign or zero extension, and the misalignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_store_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = st_data_i;
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        if (is_store_i) begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{st_data_i[7:0]}};
        end
      end
      2'b01: begin
        misalign_o = addr_lo_i[0];
        if (is_store_i) begin
          be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
          wdata_o = {2{st_data_i[15:0]}};
        end
      end
      default: misalign_o = |addr_lo_i;
    endcase
  end

  always_comb begin
    load_data_o = shifted;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data_o = {24'd0, shifted[7:0]};
      F3_HU:   load_data_o = {16'd0, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: req/ack data bus FSM, stall generation and MEM/WB register.
// Define MEM_TRACE_EN to carry debug PC / have-inst alongside the MEM/WB fields.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MEM_TRACE_EN
  input  logic [31:0]       debug_pc_i,
  input  logic              debug_have_inst_i,
  output logic [31:0]       debug_pc_o,
  output logic              debug_have_inst_o,
`endif
  input  logic              in_valid_i,
  input  logic [1:0]        wd_sel_i,
  input  logic              rf_we_i,
  input  logic              dram_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        wR_i,
  input  logic [31:0]       wD_i,
  input  logic [31:0]       alu_c_i,
  input  logic [31:0]       rD2_i,
  output logic              stall_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [3:0]        dbus_be_o,
  output logic [31:0]       dbus_wdata_o,
  input  logic              dbus_ack_i,
  input  logic [31:0]       dbus_rdata_i,
  output logic              wb_valid_o,
  output logic              rf_we_o,
  output logic [4:0]        wR_o,
  output logic [31:0]       wD_o,
  output logic              misalign_o
);

  mem_state_e state_q, state_d;

  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d, rf_we_q, rf_we_d, mis_q, mis_d;
  logic [4:0]        wr_q, wr_d;
  logic [31:0]       wd_q, wd_d;

  logic        mem_op, lane_mis, mem_go;
  logic        stall, bus_load, bus_done;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  mem_lane_align u_lane (
    .funct3_i    (funct3_i),
    .addr_lo_i   (alu_c_i[1:0]),
    .is_store_i  (dram_we_i),
    .st_data_i   (rD2_i),
    .rdata_i     (dbus_rdata_i),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .load_data_o (lane_load),
    .misalign_o  (lane_mis)
  );

  assign mem_op = in_valid_i & (dram_we_i | (wd_sel_i == WD_DRAM));
  assign mem_go = mem_op & ~lane_mis;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_go)     state_d = ST_BUSY;
      ST_BUSY: if (dbus_ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ack is only meaningful in BUSY; in IDLE it cannot affect stall or bus state.
  always_comb begin
    stall    = 1'b0;
    bus_load = 1'b0;
    bus_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall    = mem_go;
        bus_load = mem_go;
      end
      ST_BUSY: begin
        stall    = ~dbus_ack_i;
        bus_done = dbus_ack_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (bus_load) begin
      req_d   = 1'b1;
      we_d    = dram_we_i;
      addr_d  = {alu_c_i[ADDR_W-1:2], 2'b00};
      be_d    = lane_be;
      wdata_d = lane_wdata;
    end else if (bus_done) begin
      req_d = 1'b0;
    end
  end

  // Stall cycles insert a bubble; data fields keep their last values.
  always_comb begin
    wb_valid_d = 1'b0;
    rf_we_d    = 1'b0;
    mis_d      = 1'b0;
    wr_d       = wr_q;
    wd_d       = wd_q;
    if (!stall) begin
      wb_valid_d = in_valid_i;
      mis_d      = mem_op & lane_mis;
      rf_we_d    = in_valid_i & rf_we_i & (|wR_i) & ~(mem_op & lane_mis);
      wr_d       = wR_i;
      case (wd_sel_i)
        WD_ALU:  wd_d = alu_c_i;
        WD_DRAM: wd_d = lane_load;
        default: wd_d = wD_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      rf_we_q    <= 1'b0;
      mis_q      <= 1'b0;
      wr_q       <= '0;
      wd_q       <= '0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      rf_we_q    <= rf_we_d;
      mis_q      <= mis_d;
      wr_q       <= wr_d;
      wd_q       <= wd_d;
    end
  end

`ifdef MEM_TRACE_EN
  logic [31:0] dbg_pc_q;
  logic        dbg_have_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_pc_q   <= '0;
      dbg_have_q <= 1'b0;
    end else begin
      dbg_have_q <= stall ? 1'b0 : debug_have_inst_i;
      if (!stall) dbg_pc_q <= debug_pc_i;
    end
  end

  assign debug_pc_o        = dbg_pc_q;
  assign debug_have_inst_o = dbg_have_q;
`endif

  assign stall_o      = stall;
  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign rf_we_o      = rf_we_q;
  assign wR_o         = wr_q;
  assign wD_o         = wd_q;
  assign misalign_o   = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random ops
// checked against an arithmetic reference model of the MEM stage rules.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, rf_we_i, dram_we_i, dbus_ack_i;
  logic [1:0]  wd_sel_i;
  logic [2:0]  funct3_i;
  logic [4:0]  wR_i;
  logic [31:0] wD_i, alu_c_i, rD2_i, dbus_rdata_i;
  logic        stall_o, dbus_req_o, dbus_we_o, wb_valid_o, rf_we_o, misalign_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, wD_o;
  logic [3:0]  dbus_be_o;
  logic [4:0]  wR_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .wd_sel_i(wd_sel_i), .rf_we_i(rf_we_i),
    .dram_we_i(dram_we_i), .funct3_i(funct3_i), .wR_i(wR_i), .wD_i(wD_i),
    .alu_c_i(alu_c_i), .rD2_i(rD2_i), .stall_o(stall_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i), .wb_valid_o(wb_valid_o), .rf_we_o(rf_we_o),
    .wR_o(wR_o), .wD_o(wD_o), .misalign_o(misalign_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, alignment, lanes, replication, extension.
  function automatic int unsigned size_bytes(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input bit store, input logic [2:0] f3, input logic [31:0] a);
    int unsigned nb;
    nb = size_bytes(f3);
    if (!store) return 4'hF;
    return 4'(((32'd1 << nb) - 32'd1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_bytes(f3))
      1:       return {24'd0, d[7:0]} * 32'h0101_0101;
      2:       return {16'd0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    int unsigned nb;
    logic [31:0] v;
    nb = size_bytes(f3);
    v  = rdata >> (8 * (a % 4));
    if (nb == 4) return v;
    v = v & ((32'd1 << (8 * nb)) - 32'd1);
    if (!f3[2] && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  task automatic check_all_zero(input string nm);
    check({nm, ":stall"}, 32'(stall_o), 32'd0);
    check({nm, ":req"}, 32'(dbus_req_o), 32'd0);
    check({nm, ":we"}, 32'(dbus_we_o), 32'd0);
    check({nm, ":addr"}, dbus_addr_o, 32'd0);
    check({nm, ":be"}, 32'(dbus_be_o), 32'd0);
    check({nm, ":wdata"}, dbus_wdata_o, 32'd0);
    check({nm, ":wb_valid"}, 32'(wb_valid_o), 32'd0);
    check({nm, ":rf_we"}, 32'(rf_we_o), 32'd0);
    check({nm, ":wR"}, 32'(wR_o), 32'd0);
    check({nm, ":wD"}, wD_o, 32'd0);
    check({nm, ":misalign"}, 32'(misalign_o), 32'd0);
  endtask

  // Presents one op in the current cycle, answers the bus after nwait wait
  // cycles, then checks the write-back; the next op may follow immediately.
  task automatic run_op(input string nm, input bit valid, input logic [1:0] sel,
                        input bit rfwe, input bit dwe, input logic [2:0] f3,
                        input logic [4:0] wr, input logic [31:0] wd, input logic [31:0] alu,
                        input logic [31:0] rd2, input int nwait, input logic [31:0] rdata,
                        input bit spurious);
    bit mem, mis, go;
    int stalls;
    logic [31:0] exp_wd;
    mem = valid && (dwe || sel == WD_DRAM);
    mis = mem && is_misaligned(f3, alu);
    go  = mem && !mis;
    in_valid_i = valid; wd_sel_i = sel; rf_we_i = rfwe; dram_we_i = dwe;
    funct3_i = f3; wR_i = wr; wD_i = wd; alu_c_i = alu; rD2_i = rd2;
    if (spurious && !go) begin
      dbus_ack_i   = 1'b1;
      dbus_rdata_i = $urandom;
    end
    @(negedge clk);
    check({nm, ":stall_c0"}, 32'(stall_o), 32'(go));
    check({nm, ":req_c0"}, 32'(dbus_req_o), 32'd0);
    stalls = go ? 1 : 0;
    if (go) begin
      for (int k = 1; k <= nwait + 1; k++) begin
        @(posedge clk); #1;
        if (k == nwait + 1) begin
          dbus_ack_i   = 1'b1;
          dbus_rdata_i = rdata;
        end else begin
          dbus_rdata_i = $urandom;
        end
        @(negedge clk);
        check({nm, ":req"}, 32'(dbus_req_o), 32'd1);
        if (k == 1) begin
          check({nm, ":addr"}, dbus_addr_o, alu & 32'hFFFF_FFFC);
          check({nm, ":be"}, 32'(dbus_be_o), 32'(exp_be(dwe, f3, alu)));
          check({nm, ":we"}, 32'(dbus_we_o), 32'(dwe));
          if (dwe) check({nm, ":wdata"}, dbus_wdata_o, exp_wdata(f3, rd2));
        end
        check({nm, ":stall"}, 32'(stall_o), 32'(k <= nwait));
        check({nm, ":bubble_valid"}, 32'(wb_valid_o), 32'd0);
        check({nm, ":bubble_rf_we"}, 32'(rf_we_o), 32'd0);
        if (stall_o) stalls++;
      end
      check({nm, ":stall_cycles"}, 32'(stalls), 32'(nwait + 1));
    end
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    in_valid_i = 1'b0;
    case (sel)
      WD_ALU:  exp_wd = alu;
      WD_DRAM: exp_wd = exp_load(f3, alu, rdata);
      default: exp_wd = wd;
    endcase
    check({nm, ":req_after"}, 32'(dbus_req_o), 32'd0);
    check({nm, ":wb_valid"}, 32'(wb_valid_o), 32'(valid));
    check({nm, ":rf_we"}, 32'(rf_we_o), 32'(valid && rfwe && wr != 5'd0 && !mis));
    check({nm, ":misalign"}, 32'(misalign_o), 32'(mis));
    if (valid) check({nm, ":wR"}, 32'(wR_o), 32'(wr));
    if (valid && !mis) check({nm, ":wD"}, wD_o, exp_wd);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    st_f3 = '{F3_B, F3_H, F3_W};

    rst = 1'b1;
    in_valid_i = 1'b0; wd_sel_i = WD_ALU; rf_we_i = 1'b0; dram_we_i = 1'b0;
    funct3_i = 3'd0; wR_i = 5'd0; wD_i = 32'd0; alu_c_i = 32'd0; rD2_i = 32'd0;
    dbus_ack_i = 1'b0; dbus_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    run_op("add", 1'b1, WD_ALU, 1'b1, 1'b0, F3_W, 5'd5, 32'd0, 32'h0000_1234,
           32'd0, 0, 32'd0, 1'b1);
    run_op("lb", 1'b1, WD_DRAM, 1'b1, 1'b0, F3_B, 5'd7, 32'd0, 32'h0000_1003,
           32'd0, 2, 32'h80FF_FFFF, 1'b0);
    run_op("sh", 1'b1, WD_ALU, 1'b0, 1'b1, F3_H, 5'd0, 32'd0, 32'h0000_2002,
           32'hABCD_1234, 1, 32'd0, 1'b0);
    run_op("lw_mis", 1'b1, WD_DRAM, 1'b1, 1'b0, F3_W, 5'd9, 32'd0, 32'h0000_3001,
           32'd0, 0, 32'd0, 1'b0);
    run_op("lbu_x0", 1'b1, WD_DRAM, 1'b1, 1'b0, F3_BU, 5'd0, 32'd0, 32'h0000_4002,
           32'd0, 0, 32'h00AB_0000, 1'b0);
    run_op("ext", 1'b1, WD_EXT, 1'b1, 1'b0, F3_W, 5'd31, 32'h0000_0104, 32'hDEAD_0000,
           32'd0, 0, 32'd0, 1'b0);

    // Reset while BUSY abandons the access; a late ack must be ignored.
    in_valid_i = 1'b1; wd_sel_i = WD_DRAM; rf_we_i = 1'b1; dram_we_i = 1'b0;
    funct3_i = F3_W; wR_i = 5'd3; alu_c_i = 32'h0000_5000;
    @(negedge clk);
    check("rst_busy:stall_c0", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid_i = 1'b0;
    @(negedge clk);
    check("rst_busy:req_c1", 32'(dbus_req_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_busy");
    @(posedge clk); #1;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    check("late_ack:stall", 32'(stall_o), 32'd0);
    check("late_ack:req", 32'(dbus_req_o), 32'd0);
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    @(negedge clk);
    check("late_ack:wb_valid", 32'(wb_valid_o), 32'd0);
    check("late_ack:rf_we", 32'(rf_we_o), 32'd0);
    check("late_ack:req_next", 32'(dbus_req_o), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      if (kind <= 3)
        run_op("rnd_load", 1'b1, WD_DRAM, 1'($urandom), 1'b0, ld_f3[$urandom_range(0, 4)],
               5'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
               $urandom, 1'b0);
      else if (kind <= 6)
        run_op("rnd_store", 1'b1, WD_ALU, 1'b0, 1'b1, st_f3[$urandom_range(0, 2)],
               5'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
               32'd0, 1'b0);
      else if (kind <= 8)
        run_op("rnd_alu", 1'b1, (kind == 7) ? WD_ALU : 2'($urandom_range(2, 3)),
               1'($urandom), 1'b0, 3'($urandom), 5'($urandom), $urandom, $urandom,
               $urandom, 0, 32'd0, 1'($urandom));
      else
        run_op("rnd_bubble", 1'b0, 2'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
               5'($urandom), $urandom, $urandom, $urandom, 0, 32'd0, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
